// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, key/word types,
// FSM state encoding and the round-constant table.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    // Rcon[i] for rounds 1..10; any other index yields zero.
    function automatic logic [7:0] get_rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_expand_if.sv
// Request/stream bundle between a key-schedule consumer (master) and the
// key_expand block (slave).
interface key_expand_if;
    import aes_pkg::*;

    logic            start;
    aes_block_t      key;
    logic            busy;
    logic            rk_valid;
    logic [3:0]      rk_idx;
    aes_block_t      round_key;
    logic            done;
    logic [1407:0]   all_keys;

    modport master (
        output start, key,
        input  busy, rk_valid, rk_idx, round_key, done, all_keys
    );

    modport slave (
        input  start, key,
        output busy, rk_valid, rk_idx, round_key, done, all_keys
    );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 8-bit byte substitution.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the top byte, so entry n starts at bit 2040 - 8n.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = 11'd2040 - {i_byte, 3'b000};
    assign o_byte = SBOX_TABLE[w_base +: 8];

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion: streams round keys 0..10, one per clock, after a start.
// Define KEY_EXPAND_STORE_EN to also retain every round key on all_keys.
module key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    key_expand_if.slave  kx
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_e   r_state;
    ks_state_e   w_state_nxt;
    aes_block_t  r_round_key;
    aes_block_t  w_round_key_nxt;
    aes_block_t  w_next_key;
    logic [3:0]  r_rk_idx;
    logic [3:0]  w_rk_idx_nxt;
    logic [3:0]  w_idx_inc;
    logic        r_rk_valid;
    logic        w_rk_valid_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_last;
    aes_word_t   w_rot;
    aes_word_t   w_sub;
    aes_word_t   w_nw0;
    aes_word_t   w_nw1;
    aes_word_t   w_nw2;
    aes_word_t   w_nw3;

    assign w_idx_inc = r_rk_idx + 4'd1;
    assign w_last    = (r_rk_idx == LAST_IDX);

    // r_round_key doubles as the captured key, so later key changes are invisible.
    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_nw0      = r_round_key[127:96] ^ w_sub ^ {get_rcon(w_idx_inc), 24'h000000};
    assign w_nw1      = r_round_key[95:64] ^ w_nw0;
    assign w_nw2      = r_round_key[63:32] ^ w_nw1;
    assign w_nw3      = r_round_key[31:0]  ^ w_nw2;
    assign w_next_key = {w_nw0, w_nw1, w_nw2, w_nw3};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (kx.start) begin
                    w_state_nxt = ST_EXPAND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered stream outputs
    always_comb begin
        w_rk_valid_nxt  = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_rk_idx_nxt    = r_rk_idx;
        w_round_key_nxt = r_round_key;
        case (r_state)
            ST_IDLE: begin
                if (kx.start) begin
                    w_rk_valid_nxt  = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_rk_idx_nxt    = 4'd0;
                    w_round_key_nxt = kx.key;
                end else begin
                    w_rk_valid_nxt  = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (w_last) begin
                    w_rk_valid_nxt  = 1'b0;
                end else begin
                    w_rk_valid_nxt  = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_rk_idx_nxt    = w_idx_inc;
                    w_round_key_nxt = w_next_key;
                    w_done_nxt      = (w_idx_inc == LAST_IDX);
                end
            end
            default: begin
                w_rk_valid_nxt  = 1'b0;
            end
        endcase
    end

    // Stream output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rk_idx    <= 4'd0;
            r_round_key <= '0;
        end else begin
            r_rk_valid  <= w_rk_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rk_idx    <= w_rk_idx_nxt;
            r_round_key <= w_round_key_nxt;
        end
    end

    assign kx.rk_valid  = r_rk_valid;
    assign kx.busy      = r_busy;
    assign kx.done      = r_done;
    assign kx.rk_idx    = r_rk_idx;
    assign kx.round_key = r_round_key;

`ifdef KEY_EXPAND_STORE_EN
    logic [1407:0] r_all_keys;

    // Each slot is written in the same edge that presents its round key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_keys <= '0;
        end else if (w_rk_valid_nxt) begin
            for (int s = 0; s <= NUM_ROUNDS; s++) begin
                if (w_rk_idx_nxt == 4'(s)) begin
                    r_all_keys[128*s +: 128] <= w_round_key_nxt;
                end
            end
        end else begin
            r_all_keys <= r_all_keys;
        end
    end

    assign kx.all_keys = r_all_keys;
`else
    assign kx.all_keys = '0;
`endif

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: table vectors, random keys against an
// arithmetic AES key-schedule model, held-start, reset-abort and key-change cases.
module tb_key_expand;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    key_expand_if kx ();

    key_expand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kx    (kx.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [127:0] exp_rk [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {model_sbox(t[31:24]), model_sbox(t[23:16]),
                     model_sbox(t[15:8]), model_sbox(t[7:0])} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_keys(input string nm);
`ifdef KEY_EXPAND_STORE_EN
        for (int i = 0; i <= 10; i++)
            chk($sformatf("%s slot%0d", nm, i), kx.all_keys[128*i +: 128], exp_rk[i]);
`else
        chk({nm, " zero"}, {127'd0, |kx.all_keys}, 128'd0);
`endif
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " busy"}, {127'd0, kx.busy}, 128'd0);
        chk({nm, " rk_valid"}, {127'd0, kx.rk_valid}, 128'd0);
        chk({nm, " done"}, {127'd0, kx.done}, 128'd0);
        chk({nm, " rk_idx"}, {124'd0, kx.rk_idx}, 128'd0);
        chk({nm, " round_key"}, kx.round_key, 128'd0);
        chk({nm, " all_keys"}, {127'd0, |kx.all_keys}, 128'd0);
    endtask

    // One full expansion; samples every cycle on the falling edge.
    task automatic run_exp(input logic [127:0] k, input bit no_wait, input bit chg_key,
                           input bit poke, output logic [127:0] rk1, output logic [127:0] rk10);
        build_model(k);
        if (!no_wait) @(negedge clk);
        kx.key   = k;
        kx.start = 1'b1;
        @(negedge clk);
        kx.start = 1'b0;
        if (chg_key) kx.key = {128{1'b1}};
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rk_valid c%0d", i), {127'd0, kx.rk_valid}, 128'd1);
            chk($sformatf("busy c%0d", i), {127'd0, kx.busy}, 128'd1);
            chk($sformatf("rk_idx c%0d", i), {124'd0, kx.rk_idx}, 128'(i));
            chk($sformatf("round_key %0d", i), kx.round_key, exp_rk[i]);
            chk($sformatf("done c%0d", i), {127'd0, kx.done}, (i == 10) ? 128'd1 : 128'd0);
            if (i == 1) rk1 = kx.round_key;
            if (i == 10) rk10 = kx.round_key;
        end
        chk_all_keys("all_keys at done");
        if (poke) kx.start = 1'b1;
        @(negedge clk);
        kx.start = 1'b0;
        chk("post rk_valid", {127'd0, kx.rk_valid}, 128'd0);
        chk("post busy", {127'd0, kx.busy}, 128'd0);
        chk("post done", {127'd0, kx.done}, 128'd0);
        chk("post rk_idx held", {124'd0, kx.rk_idx}, 128'd10);
        chk("post round_key held", kx.round_key, exp_rk[10]);
        @(negedge clk);
        chk("idle rk_valid", {127'd0, kx.rk_valid}, 128'd0);
        chk("idle busy", {127'd0, kx.busy}, 128'd0);
        chk_all_keys("all_keys after done");
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
        bit           chg_key;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] got1;
    logic [127:0] got10;
    logic [127:0] rkey;
    int           done_cnt;
    int           m;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[1] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};

        rst_n    = 1'b0;
        kx.start = 1'b0;
        kx.key   = 128'd0;
        #3;
        chk_all_zero("reset");

        // Release reset with start already high: the first edge must accept it.
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < 3; v++) begin
            run_exp(vecs[v].key, (v == 0), vecs[v].chg_key, (v == 1), got1, got10);
            chk($sformatf("vec%0d rk1", v), got1, vecs[v].rk1);
            chk($sformatf("vec%0d rk10", v), got10, vecs[v].rk10);
        end

        for (int r = 0; r < 3; r++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_exp(rkey, 1'b0, (r == 0), 1'b1, got1, got10);
        end

        // start held high for 30 cycles: rounds in cycles 1..11 and 13..23, gap at 12.
        build_model(vecs[0].key);
        kx.key   = vecs[0].key;
        kx.start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            m = c % 12;
            if (kx.done === 1'b1 && c <= 24) done_cnt++;
            chk($sformatf("hold rk_valid c%0d", c), {127'd0, kx.rk_valid}, (m != 0) ? 128'd1 : 128'd0);
            if (m != 0) begin
                chk($sformatf("hold rk_idx c%0d", c), {124'd0, kx.rk_idx}, 128'(m - 1));
                chk($sformatf("hold round_key c%0d", c), kx.round_key, exp_rk[m-1]);
            end else begin
                chk($sformatf("hold gap busy c%0d", c), {127'd0, kx.busy}, 128'd0);
            end
        end
        kx.start = 1'b0;
        chk("hold done count", 128'(done_cnt), 128'd2);
        begin
            int n = 0;
            while (kx.busy === 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("hold drain busy", {127'd0, kx.busy}, 128'd0);
        end
        @(negedge clk);

        // Reset at rk_idx 5 aborts the expansion immediately.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        build_model(rkey);
        kx.key   = rkey;
        kx.start = 1'b1;
        @(negedge clk);
        kx.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort rk_idx 5", {124'd0, kx.rk_idx}, 128'd5);
        chk("abort round_key 5", kx.round_key, exp_rk[5]);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort immediate");
        @(posedge clk);
        #1;
        chk_all_zero("abort held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort idle rk_valid %0d", c), {127'd0, kx.rk_valid}, 128'd0);
            chk($sformatf("abort idle done %0d", c), {127'd0, kx.done}, 128'd0);
        end
        run_exp(vecs[0].key, 1'b0, 1'b0, 1'b0, got1, got10);
        chk("after abort rk10", got10, vecs[0].rk10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
